keycode_event_queue: RTL and testbench



---
 rtl/frogger_pkg.sv | 24 ++
 rtl/event_fifo.sv | 53 +++++
 rtl/keycode_event_queue.sv | 130 +++++++++++++
 tb/tb_keycode_event_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared types and keycode constants for the frogger keyboard path.
// Event records carry the USB keycode and whether it came from auto-repeat.
package frogger_pkg;

  typedef logic [7:0] key_t;

  localparam key_t KEY_NONE = 8'h00;

  typedef struct packed {
    key_t code;
    logic repeat_f;
  } key_event_t;

  // USB HID usage codes used by frogger_game
  localparam key_t KEY_W     = 8'h1A;
  localparam key_t KEY_A     = 8'h04;
  localparam key_t KEY_S     = 8'h16;
  localparam key_t KEY_D     = 8'h07;
  localparam key_t KEY_RIGHT = 8'h4F;
  localparam key_t KEY_LEFT  = 8'h50;
  localparam key_t KEY_DOWN  = 8'h51;
  localparam key_t KEY_UP    = 8'h52;

endpackage

// File: rtl/event_fifo.sv
// Show-ahead synchronous FIFO of key events; dout is the head, zero when empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module event_fifo
  import frogger_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     push,
  input  key_event_t               din,
  input  logic                     pop,
  output key_event_t               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  key_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns the NIOS keycode word into discrete key events: per-slot press detection,
// frame-based auto-repeat, a one-push-per-cycle serializer and a show-ahead FIFO.
module keycode_event_queue
  import frogger_pkg::*;
#(
  parameter int NKEYS         = 2,
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 15,
  parameter int REPEAT_PERIOD = 6
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [8*NKEYS-1:0]       keycode,
  input  logic                     frame_clk,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic                     ev_valid,
  output key_t                     ev_code,
  output logic                     ev_repeat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int             CW     = $clog2(REPEAT_DELAY + 1);
  localparam bit             REP_EN = (REPEAT_PERIOD != 0);
  localparam logic [CW-1:0]  HIT    = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0]  RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

  key_t             kc_q      [NKEYS];
  key_t             kc_prev   [NKEYS];
  key_t             pend_code [NKEYS];
  logic [CW-1:0]    rep_cnt   [NKEYS];
  logic [NKEYS-1:0] pend, pend_rep, press, rep_hit, code_chg, push_oh;
  logic             fs1, fs2, fs3, frame_tick;
  logic             push, full, empty, ovf_evt;
  key_event_t       din, head;

  // Handshake: the head (ev_code/ev_repeat) is consumed on a Clk edge where
  // pop=1 and ev_valid=1; pop while ev_valid=0 is ignored.
  assign ev_valid   = !empty;
  assign ev_code    = head.code;
  assign ev_repeat  = head.repeat_f;
  assign frame_tick = fs2 && !fs3;
  assign push       = |pend;
  assign ovf_evt    = push && full && !pop;

  // A slot presses only if its code is new to the whole previous word and not
  // already claimed by a lower slot of the current word.
  always_comb begin
    press    = '0;
    rep_hit  = '0;
    code_chg = '0;
    for (int i = 0; i < NKEYS; i++) begin
      code_chg[i] = (kc_q[i] != kc_prev[i]);
      press[i]    = (kc_q[i] != KEY_NONE);
      for (int j = 0; j < NKEYS; j++) begin
        if (kc_prev[j] == kc_q[i]) press[i] = 1'b0;
        if (j < i && kc_q[j] == kc_q[i]) press[i] = 1'b0;
      end
      rep_hit[i] = REP_EN && frame_tick && !code_chg[i] &&
                   (kc_q[i] != KEY_NONE) && (rep_cnt[i] == HIT);
    end
  end

  // Lowest pending slot wins the single push slot of the cycle.
  always_comb begin
    push_oh = '0;
    din     = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        push_oh     = '0;
        push_oh[i]  = 1'b1;
        din.code     = pend_code[i];
        din.repeat_f = pend_rep[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs1      <= 1'b0;
      fs2      <= 1'b0;
      fs3      <= 1'b0;
      pend     <= '0;
      pend_rep <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NKEYS; i++) begin
        kc_q[i]      <= KEY_NONE;
        kc_prev[i]   <= KEY_NONE;
        pend_code[i] <= KEY_NONE;
        rep_cnt[i]   <= '0;
      end
    end else begin
      fs1 <= frame_clk;
      fs2 <= fs1;
      fs3 <= fs2;
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      for (int i = 0; i < NKEYS; i++) begin
        kc_q[i]    <= keycode[8*i +: 8];
        kc_prev[i] <= kc_q[i];
        // A fresh press or repeat on the slot being pushed re-arms it.
        if (press[i] || rep_hit[i]) begin
          pend[i]      <= 1'b1;
          pend_code[i] <= kc_q[i];
          pend_rep[i]  <= !press[i];
        end else if (push_oh[i]) begin
          pend[i] <= 1'b0;
        end
        if (code_chg[i])
          rep_cnt[i] <= '0;
        else if (REP_EN && frame_tick && kc_q[i] != KEY_NONE)
          rep_cnt[i] <= rep_hit[i] ? RELOAD : rep_cnt[i] + CW'(1);
      end
    end
  end

  event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .dout    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue: tap, multi-key, auto-repeat, overflow,
// empty pop and async reset, with a second instance that has auto-repeat off.
module tb_keycode_event_queue;
  import frogger_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keycode;
  logic        frame_clk;
  logic        pop;
  logic        clr_ovf;
  logic        ev_valid, ev_repeat, overflow;
  key_t        ev_code;
  logic [3:0]  count;
  logic        pop2 = 1'b0;
  logic        clr2 = 1'b0;
  logic        v2, r2, o2;
  key_t        c2;
  logic [3:0]  n2;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  keycode_event_queue dut (
    .Clk(clk), .Reset_n(rst_n), .keycode(keycode), .frame_clk(frame_clk),
    .pop(pop), .clr_ovf(clr_ovf), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_repeat(ev_repeat), .count(count), .overflow(overflow)
  );

  keycode_event_queue #(.REPEAT_PERIOD(0)) dut_norep (
    .Clk(clk), .Reset_n(rst_n), .keycode(keycode), .frame_clk(frame_clk),
    .pop(pop2), .clr_ovf(clr2), .ev_valid(v2), .ev_code(c2),
    .ev_repeat(r2), .count(n2), .overflow(o2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    cyc(4);
    frame_clk = 1'b0;
    cyc(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_rep;
    rst_n = 1'b0; keycode = '0; frame_clk = 1'b0; pop = 1'b0; clr_ovf = 1'b0;
    cyc(3);
    check("rst_valid", ev_valid, 0);
    check("rst_code", ev_code, 0);
    check("rst_repeat", ev_repeat, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    cyc(2);

    // tap for one cycle
    keycode = 16'h001A;
    cyc(1);
    keycode = 16'h0000;
    check("tap_valid_e", ev_valid, 0);
    cyc(1);
    check("tap_valid_e1", ev_valid, 0);
    cyc(1);
    check("tap_valid_e2", ev_valid, 1);
    check("tap_code", ev_code, 8'h1A);
    check("tap_repeat", ev_repeat, 0);
    cyc(5);
    check("tap_count", count, 1);
    pop_one();
    check("tap_popped", count, 0);

    // two simultaneous presses, then a slot swap
    keycode = 16'h071A;
    cyc(3);
    check("two_count_e2", count, 1);
    check("two_head", ev_code, 8'h1A);
    cyc(1);
    check("two_count_e3", count, 2);
    keycode = 16'h1A07;
    cyc(6);
    check("swap_count", count, 2);
    check("two_first", ev_code, 8'h1A);
    pop_one();
    check("two_second", ev_code, 8'h07);
    pop_one();
    keycode = 16'h0000;
    cyc(3);
    check("release_count", count, 0);

    // nine distinct presses into an 8-deep queue
    for (int k = 1; k <= 9; k++) begin
      keycode = 16'(k);
      cyc(2);
      if (k <= 8) exp_q.push_back(8'(k));
    end
    cyc(4);
    check("full_count", count, 8);
    check("full_ovf", overflow, 1);
    check("full_head", ev_code, 8'h01);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("clr_ovf", overflow, 0);

    // push and pop on the same edge while full
    keycode = 16'h000A;
    cyc(2);
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h0A);
    check("pp_count", count, 8);
    check("pp_ovf", overflow, 0);
    check("pp_head", ev_code, 8'h02);

    // clear and new overflow on the same edge: flag stays set
    keycode = 16'h000B;
    cyc(2);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("clr_vs_ovf", overflow, 1);
    check("drop_count", count, 8);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("clr_ovf2", overflow, 0);

    keycode = 16'h0000;
    cyc(3);
    for (int k = 0; k < 8; k++) begin
      check("drain", ev_code, exp_q.pop_front());
      pop_one();
    end
    check("drain_count", count, 0);
    check("drain_valid", ev_valid, 0);
    pop_one();
    check("empty_pop_count", count, 0);
    check("empty_pop_valid", ev_valid, 0);
    check("empty_pop_ovf", overflow, 0);

    // async reset with three queued and one pending, key held through release
    keycode = 16'h0011; cyc(2);
    keycode = 16'h0012; cyc(2);
    keycode = 16'h0013; cyc(4);
    check("pre_rst_count", count, 3);
    keycode = 16'h001A;
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", ev_valid, 0);
    check("arst_code", ev_code, 0);
    check("arst_ovf", overflow, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    check("held_count", count, 1);
    check("held_code", ev_code, 8'h1A);
    check("held_repeat", ev_repeat, 0);
    cyc(3);
    check("held_once", count, 1);

    // auto-repeat: press event, then repeats at ticks 15, 21, 27
    keycode = 16'h0000;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    keycode = 16'h0004;
    cyc(4);
    check("rep_press_count", count, 1);
    check("rep_press_code", ev_code, 8'h04);
    check("rep_press_flag", ev_repeat, 0);
    pop_one();
    for (int t = 1; t <= 30; t++) begin
      frame_pulse();
      exp_rep = (t == 15 || t == 21 || t == 27);
      check($sformatf("rep_tick%0d_count", t), count, 32'(exp_rep));
      if (exp_rep) begin
        check($sformatf("rep_tick%0d_code", t), ev_code, 8'h04);
        check($sformatf("rep_tick%0d_flag", t), ev_repeat, 1);
        pop_one();
      end
    end
    check("norep_count", n2, 1);
    check("norep_code", c2, 8'h04);
    check("norep_flag", r2, 0);
    check("norep_valid", v2, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
